burst_read_fsm: RTL and testbench
=================================

Name: burst_read_fsm

Overview:
Parametrised read-sequencer FSM that fetches a burst of consecutive words from a slow memory port. It uses READ/DLY handshaking with a wait-state input `ws` and adds burst length, address increment, per-beat data capture, wait-state timeout and an error exit. It sits between a requesting datapath, which issues `go`, and a synchronous memory or peripheral that signals not-ready on `ws`.

Parameters:
AW, 16, address width (bits)
DW, 16, data width (bits)
LEN_W, 4, width of burst_len field; bursts of 1..2^LEN_W beats
TMO, 15, max consecutive wait-state retries per beat before abort; 0 = never time out

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
go  in  1  start request, sampled only in IDLE
start_addr  in  AW  first beat address, latched with go
burst_len  in  LEN_W  beats minus 1, latched with go
ws  in  1  memory wait state: 1 = data not ready this DLY cycle
mem_rdata  in  DW  memory read data, valid in DLY when ws=0
rd  out  1  memory read strobe
mem_addr  out  AW  current beat address
rdata  out  DW  captured read data
rdata_vld  out  1  one-cycle pulse per captured beat
ds  out  1  done strobe, one cycle, burst completed
err  out  1  error strobe, one cycle, burst aborted on timeout
busy  out  1  high in every state except IDLE

Behaviour:
- Reset is asynchronous via rst_n, clock is clk. During and after reset:
  - state = IDLE; addr_reg, beat_cnt, retry_cnt, rdata = 0.
  - rd, rdata_vld, ds, err, busy = 0.
  - Reset asserted mid-burst aborts immediately with no ds and no err.
- States (3-bit register): IDLE, READ, DLY, DONE, ERR. Two-process style: state register plus combinational next-state logic.
- rd, ds, err and busy are decoded from the state register only (Moore). mem_addr = addr_reg.
- IDLE:
  - go=1 -> latch start_addr into addr_reg and burst_len into len_reg; clear beat_cnt and retry_cnt; go to READ.
  - Otherwise stay in IDLE.
- READ: rd=1. Unconditionally go to DLY.
- DLY: rd=1.
  - ws=0: on this edge rdata <= mem_rdata and rdata_vld <= 1 (registered, so it is visible the following cycle). Clear retry_cnt.
    - If beat_cnt == len_reg -> DONE.
    - Else addr_reg+1 and beat_cnt+1 -> READ.
  - ws=1 and (TMO==0 or retry_cnt != TMO-1): retry_cnt+1, go to READ with the same address.
  - ws=1 and TMO!=0 and retry_cnt == TMO-1: go to ERR.
- DONE: ds=1 for one cycle -> IDLE.
- ERR: err=1 for one cycle -> IDLE. Beats already delivered remain valid. No ds.
- rdata_vld is high for exactly one cycle per accepted beat. The last beat's pulse coincides with the DONE cycle.
- rdata holds its last captured value until the next capture.
- go is ignored while busy=1. go asserted in the same cycle the FSM is in DONE or ERR is also ignored. Start requires IDLE.
- addr_reg increments modulo 2^AW (0xFFFF+1 = 0x0000 for AW=16).
- burst_len is a LEN_W-bit count of beats minus 1. The maximum value gives 2^LEN_W beats with no overflow; beat_cnt is LEN_W bits.
- Latency with zero wait states:
  - go sampled at edge 0; READ in cycle 1, DLY in cycle 2.
  - An N-beat burst has ds in cycle 2N+1 after the go edge.
  - busy is high for 2N+1 cycles.
- Each ws=1 DLY cycle adds 2 cycles (one READ + one DLY).
- Timeout happens after TMO consecutive ws=1 DLY cycles on one beat.
- Inputs are synchronous to clk; no internal synchronisers.

Test Plan:
1. Single beat: go with start_addr=0x0010, burst_len=0, ws=0, mem_rdata=0xBEEF.
   -> rd high in cycles 1-2, mem_addr=0x0010, rdata=0xBEEF with rdata_vld in cycle 3, ds in cycle 3, busy for 3 cycles, err=0.
2. Burst: start_addr=0x00FE, burst_len=3, ws=0, mem_rdata = address+0x1000.
   -> mem_addr sequence 0x00FE, 0x00FF, 0x0100, 0x0101; 4 rdata_vld pulses carrying 0x10FE..0x1101; ds in cycle 9; busy for 9 cycles.
3. Wrap: start_addr=0xFFFF, burst_len=1.
   -> addresses 0xFFFF then 0x0000; ds asserted; err=0.
4. Wait states: burst_len=1, ws=1 for the first 2 DLY cycles of beat 0.
   -> READ/DLY repeats at the same address; no rdata_vld during waits; 2 beats delivered; ds in cycle 9; err=0.
5. Timeout (TMO=15): ws held at 1.
   -> 15 DLY cycles at start_addr, then err high for one cycle, no ds, no rdata_vld, back to IDLE. A subsequent go with ws=0 completes normally.
6. Robustness:
   - go held high through a 2-beat burst -> exactly one burst runs; a new burst starts only after returning to IDLE.
   - rst_n pulsed low in DLY of beat 1 -> all outputs 0 asynchronously, state IDLE, no ds.

Source files
------------

// File: rtl/burst_read_fsm.sv
// Burst read sequencer: fetches 1..2^LEN_W consecutive words from a slow memory
// port using a READ/DLY handshake, with per-beat wait-state retry and timeout abort.
module burst_read_fsm #(
  parameter int AW    = 16,
  parameter int DW    = 16,
  parameter int LEN_W = 4,
  parameter int TMO   = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [AW-1:0]    start_addr,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             ws,
  input  logic [DW-1:0]    mem_rdata,
  output logic             rd,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    rdata,
  output logic             rdata_vld,
  output logic             ds,
  output logic             err,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_DLY  = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  // Retry counter only has to reach TMO-1; with TMO=0 it simply wraps and is never compared.
  localparam int RW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [RW-1:0] RETRY_LAST = RW'((TMO > 0) ? TMO - 1 : 0);

  state_t           r_state;
  logic [AW-1:0]    r_addr;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_beat_cnt;
  logic [RW-1:0]    r_retry_cnt;
  logic [DW-1:0]    r_rdata;
  logic             r_rdata_vld;
  logic             w_timeout;

  assign w_timeout = (TMO != 0) && (r_retry_cnt == RETRY_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values; the asynchronous reset clears every register, datapath included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_len       <= '0;
      r_beat_cnt  <= '0;
      r_retry_cnt <= '0;
      r_rdata     <= '0;
      r_rdata_vld <= 1'b0;
    end else begin
      r_rdata_vld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (go) begin
            r_addr      <= start_addr;
            r_len       <= burst_len;
            r_beat_cnt  <= '0;
            r_retry_cnt <= '0;
            r_state     <= S_READ;
          end
        end
        S_READ: r_state <= S_DLY;
        S_DLY: begin
          if (!ws) begin
            r_rdata     <= mem_rdata;
            r_rdata_vld <= 1'b1;
            r_retry_cnt <= '0;
            if (r_beat_cnt == r_len) begin
              r_state <= S_DONE;
            end else begin
              r_addr     <= r_addr + AW'(1);
              r_beat_cnt <= r_beat_cnt + LEN_W'(1);
              r_state    <= S_READ;
            end
          end else if (w_timeout) begin
            r_state <= S_ERR;
          end else begin
            r_retry_cnt <= r_retry_cnt + RW'(1);
            r_state     <= S_READ;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        S_ERR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes are pure decodes of the state register, so they carry no input-to-output path.
  assign rd        = (r_state == S_READ) || (r_state == S_DLY);
  assign ds        = (r_state == S_DONE);
  assign err       = (r_state == S_ERR);
  assign busy      = (r_state != S_IDLE);
  assign mem_addr  = r_addr;
  assign rdata     = r_rdata;
  assign rdata_vld = r_rdata_vld;

endmodule

// File: tb/tb_burst_read_fsm.sv
// Self-checking bench for burst_read_fsm: each burst is expanded into an expected
// per-cycle trace from wait counts per beat, and a compare process checks every cycle.
module tb_burst_read_fsm;

  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int LEN_W = 4;
  localparam int TMO   = 15;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             go;
  logic [AW-1:0]    start_addr;
  logic [LEN_W-1:0] burst_len;
  logic             ws;
  logic [DW-1:0]    mem_rdata;
  logic             rd;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    rdata;
  logic             rdata_vld;
  logic             ds;
  logic             err;
  logic             busy;

  burst_read_fsm #(.AW(AW), .DW(DW), .LEN_W(LEN_W), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .start_addr(start_addr), .burst_len(burst_len),
    .ws(ws), .mem_rdata(mem_rdata), .rd(rd), .mem_addr(mem_addr), .rdata(rdata),
    .rdata_vld(rdata_vld), .ds(ds), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  // One expected cycle: outputs to see, plus the inputs to drive during that cycle.
  typedef struct {
    logic        rd, busy, vld, ds, err;
    logic [15:0] addr, rdata;
    logic        drv_ws, drv_go;
    logic [15:0] drv_rdata;
  } ent_t;

  ent_t        plan[$];
  ent_t        exp_q[$];
  int          waits[16];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] model_addr  = '0;
  logic [15:0] model_rdata = '0;
  logic        m_pend      = 1'b0;
  logic [15:0] m_pend_d    = '0;
  logic [15:0] m_sa        = '0;
  logic [3:0]  m_len       = '0;
  int          data_mode   = 0;
  logic [15:0] data_const  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic void add(input logic e_rd, input logic e_busy, input logic e_ds,
                              input logic e_err, input logic d_ws, input logic d_go,
                              input logic [15:0] addr, input logic [15:0] d_rdata);
    ent_t e;
    e.rd = e_rd; e.busy = e_busy; e.ds = e_ds; e.err = e_err;
    e.vld = m_pend;
    if (m_pend) model_rdata = m_pend_d;
    m_pend      = 1'b0;
    e.rdata     = model_rdata;
    model_addr  = addr;
    e.addr      = addr;
    e.drv_ws    = d_ws;
    e.drv_go    = d_go;
    e.drv_rdata = d_rdata;
    plan.push_back(e);
  endfunction

  function automatic logic gsel(input bit hold);
    return hold ? 1'b1 : 1'($urandom);
  endfunction

  function automatic logic [15:0] beat_data(input logic [15:0] a);
    if (data_mode == 1) return a + 16'h1000;
    if (data_mode == 2) return data_const;
    return 16'($urandom);
  endfunction

  // Expected trace: idle/go cycle, then per beat (waits x READ+DLY(ws=1)), READ+DLY(ws=0),
  // then DONE; a beat reaching TMO wait cycles ends in ERR instead.
  task automatic build(input logic [15:0] sa, input logic [3:0] len, input bit hold);
    logic [15:0] a;
    logic [15:0] d;
    int          nw;
    plan.delete();
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom), 1'b1, model_addr, 16'($urandom));
    for (int b = 0; b <= int'(len); b++) begin
      a  = sa + 16'(b);
      nw = (TMO != 0 && waits[b] > TMO) ? TMO : waits[b];
      for (int k = 0; k < nw; k++) begin
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'($urandom), gsel(hold), a, 16'($urandom));
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, gsel(hold), a, 16'($urandom));
      end
      if (TMO != 0 && waits[b] >= TMO) begin
        add(1'b0, 1'b1, 1'b0, 1'b1, 1'($urandom), 1'b1, a, 16'($urandom));
        return;
      end
      d = beat_data(a);
      add(1'b1, 1'b1, 1'b0, 1'b0, 1'($urandom), gsel(hold), a, 16'($urandom));
      add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, gsel(hold), a, d);
      m_pend   = 1'b1;
      m_pend_d = d;
    end
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'($urandom), 1'b1, model_addr, 16'($urandom));
  endtask

  task automatic drive_plan(input int upto);
    for (int i = 0; i < upto; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      exp_q.push_back(plan[i]);
      go        = plan[i].drv_go;
      ws        = plan[i].drv_ws;
      mem_rdata = plan[i].drv_rdata;
      if (i == 0) begin
        start_addr = m_sa;
        burst_len  = m_len;
      end else begin
        start_addr = 16'($urandom);
        burst_len  = 4'($urandom);
      end
    end
  endtask

  task automatic run(input logic [15:0] sa, input logic [3:0] len, input bit hold);
    @(posedge clk);
    #1;
    m_sa  = sa;
    m_len = len;
    build(sa, len, hold);
    drive_plan(plan.size());
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      plan.delete();
      add(1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom), 1'b0, model_addr, 16'($urandom));
      drive_plan(1);
    end
  endtask

  task automatic clear_waits();
    for (int i = 0; i < 16; i++) waits[i] = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd"},    32'(rd),        32'd0);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_ds"},    32'(ds),        32'd0);
    check({tag, "_err"},   32'(err),       32'd0);
    check({tag, "_vld"},   32'(rdata_vld), 32'd0);
    check({tag, "_addr"},  32'(mem_addr),  32'd0);
    check({tag, "_rdata"}, 32'(rdata),     32'd0);
  endtask

  // Single compare process: one expected entry per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    ent_t ce;
    if (exp_q.size() != 0) begin
      ce = exp_q.pop_front();
      check("rd",        32'(rd),        32'(ce.rd));
      check("busy",      32'(busy),      32'(ce.busy));
      check("ds",        32'(ds),        32'(ce.ds));
      check("err",       32'(err),       32'(ce.err));
      check("rdata_vld", 32'(rdata_vld), 32'(ce.vld));
      check("mem_addr",  32'(mem_addr),  32'(ce.addr));
      check("rdata",     32'(rdata),     32'(ce.rdata));
    end
  end

  initial begin
    rst_n = 1'b0; go = 1'b0; start_addr = '0; burst_len = '0; ws = 1'b0; mem_rdata = '0;
    clear_waits();
    #3;
    check_all_zero("reset");
    #9;
    rst_n = 1'b1;

    // Single beat with fixed data.
    data_mode = 2; data_const = 16'hBEEF;
    run(16'h0010, 4'd0, 1'b0);
    check("t1_cycles", 32'(plan.size() - 1), 32'd3);
    check("t1_rdata",  32'(rdata),    32'h0000BEEF);
    check("t1_ds",     32'(ds),       32'd1);
    check("t1_addr",   32'(mem_addr), 32'h00000010);

    // Four-beat burst crossing a byte boundary, data = address + 0x1000.
    data_mode = 1;
    run(16'h00FE, 4'd3, 1'b0);
    check("t2_cycles", 32'(plan.size() - 1), 32'd9);
    check("t2_rdata",  32'(rdata),    32'h00001101);
    check("t2_addr",   32'(mem_addr), 32'h00000101);

    // Address wrap.
    run(16'hFFFF, 4'd1, 1'b0);
    check("t3_cycles", 32'(plan.size() - 1), 32'd5);
    check("t3_addr",   32'(mem_addr), 32'h00000000);
    check("t3_rdata",  32'(rdata),    32'h00001000);

    // Two wait states on beat 0.
    waits[0] = 2;
    run(16'h1234, 4'd1, 1'b0);
    check("t4_cycles", 32'(plan.size() - 1), 32'd9);
    check("t4_ds",     32'(ds), 32'd1);
    clear_waits();

    // Timeout: ws stuck high on beat 0.
    waits[0] = 20;
    run(16'h0500, 4'd2, 1'b0);
    check("t5_cycles", 32'(plan.size() - 1), 32'd31);
    check("t5_err",    32'(err),      32'd1);
    check("t5_ds",     32'(ds),       32'd0);
    check("t5_addr",   32'(mem_addr), 32'h00000500);
    clear_waits();
    run(16'h0500, 4'd0, 1'b0);
    check("t5_recover_ds", 32'(ds), 32'd1);

    // go held high: back-to-back bursts, each starting only from IDLE.
    data_mode = 0;
    run(16'h0200, 4'd1, 1'b1);
    run(16'h0300, 4'd0, 1'b1);
    idle_cycles(2);

    // Reset asserted during DLY of beat 1.
    @(posedge clk);
    #1;
    m_sa = 16'h0A00; m_len = 4'd1;
    build(16'h0A00, 4'd1, 1'b0);
    drive_plan(5);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    go    = 1'b0;
    #1;
    check_all_zero("midrst");
    repeat (2) begin
      @(negedge clk);
      check("midrst_hold_ds",   32'(ds),   32'd0);
      check("midrst_hold_busy", 32'(busy), 32'd0);
    end
    #1;
    rst_n = 1'b1;
    model_addr = '0; model_rdata = '0; m_pend = 1'b0;

    // Randomized bursts with random wait states, occasional timeouts and idle gaps.
    for (int t = 0; t < 60; t++) begin
      for (int b = 0; b < 16; b++)
        waits[b] = ($urandom_range(0, 15) == 0) ? int'($urandom_range(15, 17))
                                                : int'($urandom_range(0, 3));
      run(16'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) idle_cycles(int'($urandom_range(0, 2)));
    end

    idle_cycles(1);
    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
